// File: rtl/bus_gnrtr_arbiter.sv
// bus_gnrtr_arbiter: round-robin shared-bus arbiter that pops one packet at a time and routes it by header dest ID.
// Optional macro BUS_BROADCAST_EN: dest==broadcast is delivered to every endpoint except the source.
module bus_gnrtr_arbiter #(
    parameter int bits = 1,
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic clk,
    input  logic reset,
    input  logic [bits-1:0][drvrs-1:0] pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0] pop,
    output logic [bits-1:0][drvrs-1:0] push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
    localparam int IW = $clog2(drvrs);
    typedef enum logic [1:0] {IDLE, POP, DELIVER} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, g;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [7:0] dest;
    logic [drvrs-1:0] pop_v, push_v;
    int idx;

    assign dest = pkt_q[pckg_sz-1 -: 8];

    // Scan farthest-first so the nearest pending endpoint after last_q ends up winning.
    always_comb begin
        g = last_q;
        idx = 0;
        for (int k = drvrs; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= drvrs) idx = idx - drvrs;
            if (pndng[0][IW'(idx)]) g = IW'(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        pkt_d = pkt_q;
        pop_v = '0;
        push_v = '0;
        case (state_q)
            IDLE: begin
                if (|pndng[0]) begin
                    grant_d = g;
                    state_d = POP;
                end
            end
            POP: begin
                pop_v[grant_q] = 1'b1;
                pkt_d = D_pop[0][grant_q];
                last_d = grant_q;
                state_d = DELIVER;
            end
            DELIVER: begin
                state_d = IDLE;
                if (int'(dest) < drvrs) push_v[dest[IW-1:0]] = 1'b1;
`ifdef BUS_BROADCAST_EN
                else if (dest == broadcast) push_v = ~(drvrs'(1) << grant_q);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are masked while reset is high so an abort during DELIVER suppresses the push at once.
    always_comb begin
        pop = '0;
        push = '0;
        D_push = '0;
        if (!reset) begin
            pop[0] = pop_v;
            push[0] = push_v;
            for (int i = 0; i < drvrs; i++) D_push[0][i] = pkt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= IW'(drvrs - 1);
            pkt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            pkt_q <= pkt_d;
        end
    end
endmodule

// File: tb/tb_bus_gnrtr_arbiter.sv
// tb_bus_gnrtr_arbiter: scoreboard bench with per-endpoint FIFO queues and a transaction-level round-robin model.
module tb_bus_gnrtr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:0][3:0] pndng, pop, push;
    logic [0:0][3:0][15:0] d_pop, d_push;

    always #5 clk = ~clk;

    bus_gnrtr_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(rst), .pndng(pndng), .D_pop(d_pop),
        .pop(pop), .push(push), .D_push(d_push)
    );

    typedef struct {int cyc; logic [3:0] mask; logic [15:0] data;} exp_t;
    exp_t pop_q[$];
    exp_t push_q[$];
    logic [15:0] fifo[4][$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] m_dp = 16'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] route(input logic [15:0] p, input int src);
        logic [7:0] d;
        logic [3:0] others;
        d = p[15:8];
        others = 4'hF & ~4'(1 << src);
        if (d < 8'd4) return 4'(1 << d);
`ifdef BUS_BROADCAST_EN
        if (d == 8'hFF) return others;
`else
        if (d == 8'hFF && others == 4'h0) return 4'h0;
`endif
        return 4'h0;
    endfunction

    function automatic logic [15:0] rand_pkt();
        int r;
        logic [7:0] d;
        r = int'($urandom_range(0, 9));
        d = r < 6 ? 8'(r % 4) : r < 8 ? 8'hFF : r == 8 ? 8'h07 : 8'($urandom);
        return {d, 8'($urandom)};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            pndng[0][i] = fifo[i].size() > 0;
            d_pop[0][i] = fifo[i].size() > 0 ? fifo[i][0] : 16'h0;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) chk("reset_outputs", 64'({pop[0], push[0]}), 64'(0));
            if (|pop[0]) begin
                if (pop_q.size() == 0) chk("pop_extra", 64'(pop[0]), 64'(0));
                else begin
                    e = pop_q.pop_front();
                    chk("pop_mask", 64'(pop[0]), 64'(e.mask));
                    chk("pop_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            while (pop_q.size() > 0 && pop_q[0].cyc < cyc) begin
                chk("pop_missing", 64'(0), 64'(pop_q[0].mask));
                void'(pop_q.pop_front());
            end
            if (|push[0]) begin
                if (push_q.size() == 0) chk("push_extra", 64'(push[0]), 64'(0));
                else begin
                    e = push_q.pop_front();
                    chk("push_mask", 64'(push[0]), 64'(e.mask));
                    chk("push_cycle", 64'(cyc), 64'(e.cyc));
                    chk("push_data", 64'(d_push[0]), 64'({4{e.data}}));
                end
            end
            while (push_q.size() > 0 && push_q[0].cyc < cyc) begin
                chk("push_missing", 64'(0), 64'(push_q[0].mask));
                void'(push_q.pop_front());
            end
            chk("pop_onehot", 64'($countones(pop[0]) <= 1), 64'(1));
            chk("pop_push_excl", 64'((|pop[0]) && (|push[0])), 64'(0));
            chk("d_push_hold", 64'(d_push[0]), rst ? 64'(0) : 64'({4{m_dp}}));
        end
    end

    initial begin
        int m_last, m_next, m_dlv, m_w, rst_until, idx;
        bit aborted, found;
        logic [15:0] m_pkt;
        logic [3:0] mk;
        m_last = 3; m_next = 0; m_dlv = -1; m_w = 0; rst_until = 5; aborted = 0; m_pkt = 16'h0;
        fifo[0].push_back(16'h02AB);
        fifo[1].push_back(16'hFF5A);
        fifo[2].push_back(16'h0123);
        fifo[3].push_back(16'h0711);
        for (int i = 0; i < 4; i++) fifo[i].push_back(16'h0340 | 16'(i));
        drive();
        repeat (3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst && cyc >= rst_until) rst = 1'b0;
            if (cyc == m_dlv) begin
                void'(fifo[m_w].pop_front());
                m_dp = m_pkt;
                if (!aborted && cyc >= 1500) begin
                    // Reset lands in DELIVER: the popped packet is lost and arbitration restarts at endpoint 0.
                    rst = 1'b1;
                    rst_until = cyc + 2;
                    aborted = 1;
                    m_dp = 16'h0;
                    m_last = 3;
                    m_next = cyc + 2;
                    if (push_q.size() > 0 && push_q[$].cyc == cyc) void'(push_q.pop_back());
                end
            end
            if (cyc > 60 && cyc < 2900)
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 7) == 0 && fifo[i].size() < 4) fifo[i].push_back(rand_pkt());
            drive();
            if (!rst && cyc >= m_next) begin
                found = 0;
                idx = 0;
                for (int k = 1; k <= 4; k++)
                    if (!found && fifo[(m_last + k) % 4].size() > 0) begin
                        found = 1;
                        idx = (m_last + k) % 4;
                    end
                if (found) begin
                    m_w = idx;
                    m_last = idx;
                    m_pkt = fifo[idx][0];
                    pop_q.push_back('{cyc + 1, 4'(1 << idx), m_pkt});
                    mk = route(m_pkt, idx);
                    if (mk != 4'h0) push_q.push_back('{cyc + 2, mk, m_pkt});
                    m_dlv = cyc + 2;
                    m_next = cyc + 3;
                end
            end
        end
        @(negedge clk);
        #1;
        chk("aborted_once", 64'(aborted), 64'(1));
        chk("pop_drain", 64'(pop_q.size()), 64'(0));
        chk("push_drain", 64'(push_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
